jam_cost_responder: RTL
=======================

Name: jam_cost_responder

Overview:
- Responder side of the job-assignment cost interface: holds the N x N worker/job cost matrix and answers the solver's (W, J) lookups with Cost.
- The matrix is loaded serially from a host stream before the solve.
- While the solver runs, the block counts lookup cycles.
- When the solver raises Valid, the block captures MinCost and MatchCount for the host.

Parameters:
- N, 8, number of workers and jobs; index width is log2(N) = 3.
- COST_W, 7, width of one cost entry.
- SUM_W, 10, width of MinCost.
- MC_W, 4, width of MatchCount.
- QCNT_W, 16, width of the lookup-cycle counter.

Ports:
- CLK  in  1  clock; all registers update on the rising edge.
- RST_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; starts or restarts a matrix load.
- load_valid  in  1  load beat qualifier.
- load_data  in  COST_W  cost entry, row-major order (entry index = W*N + J).
- load_ready  out  1  high while in LOAD; a beat is accepted when load_valid && load_ready.
- W  in  3  worker index from the solver.
- J  in  3  job index from the solver.
- Cost  out  COST_W  table[W][J].
- serve_ready  out  1  high in SERVE; releases the solver.
- Valid  in  1  solver done.
- MinCost  in  SUM_W  solver result.
- MatchCount  in  MC_W  solver result.
- res_valid  out  1  captured result valid.
- res_min_cost  out  SUM_W  captured MinCost.
- res_match_count  out  MC_W  captured MatchCount.
- query_cnt  out  QCNT_W  number of cycles spent in SERVE; saturates at all-ones.

Behaviour:
- Reset is asynchronous and active-low.
  - State goes to IDLE.
  - Table entries, load address, query_cnt, res_* all reset to 0.
  - res_valid, serve_ready and load_ready reset to 0.
  - Asserting RST_n low mid-load or mid-solve aborts immediately; all contents are discarded.
- States: IDLE, LOAD, SERVE, DONE; 2-bit state register.
- IDLE -> LOAD on load_start.
  - Other inputs are ignored in IDLE.
  - Cost = 0 in IDLE.
- LOAD:
  - load_ready = 1.
  - Each accepted beat writes table[addr] <= load_data, then addr <= addr + 1.
  - addr is 6 bits and starts at 0.
  - The beat that writes addr = N*N-1 moves the state to SERVE on the next edge; addr wraps to 0.
  - load_valid low stalls with no write.
  - load_start in LOAD resets addr to 0 and stays in LOAD. When load_start and load_valid are high in the same cycle, the beat is written at addr 0 and addr becomes 1.
  - Cost = 0 during LOAD.
- SERVE:
  - serve_ready = 1.
  - Cost is combinational from the table: table[W*N + J], zero latency. The solver samples it in the same cycle it drives W/J.
  - query_cnt increments by 1 every SERVE cycle and saturates at 2^QCNT_W - 1.
  - Valid = 1 in SERVE:
    - capture res_min_cost <= MinCost and res_match_count <= MatchCount;
    - set res_valid <= 1;
    - next state is DONE.
    - The cycle in which Valid is seen is still counted.
  - load_start in SERVE returns to LOAD with addr = 0. It takes priority over a simultaneous Valid: no capture, query_cnt cleared.
- DONE:
  - Cost is still served from the table; serve_ready = 0.
  - query_cnt is frozen.
  - res_* hold their values; further Valid pulses are ignored.
  - load_start -> LOAD; res_valid, res_min_cost, res_match_count and query_cnt are cleared to 0 on that edge.
- Entering LOAD from any state clears res_valid and query_cnt. Table contents persist until overwritten beat by beat.
- Widths:
  - Cost is COST_W bits, unsigned; no arithmetic on it in this block.
  - Index = {W, J} concatenation, which equals W*8 + J for N = 8.
- All outputs are registered except Cost, load_ready and serve_ready, which decode combinationally from the state and table.

Test Plan:
- Reset then load: release RST_n, pulse load_start, stream 64 beats with data = (W*8+J) mod 128, no gaps.
  - load_ready stays high for exactly 64 accepted beats.
  - serve_ready rises the cycle after the 64th beat.
  - W=5, J=3 -> Cost = 43.
- Stalled load: same stream with load_valid low on every 3rd cycle.
  - Table matches the gap-free case.
  - SERVE is entered only after the 64th accepted beat.
- Solve capture: after the load, hold SERVE for 100 cycles, then drive Valid=1, MinCost=10'd312, MatchCount=4'd2.
  - Next cycle: res_valid=1, res_min_cost=312, res_match_count=2, query_cnt=101, state DONE.
  - A later Valid with MinCost=5 leaves res_* unchanged.
- Reload priority: in SERVE, assert load_start and Valid in the same cycle.
  - State goes to LOAD; res_valid=0; query_cnt=0; load_ready=1.
- Mid-load reset: pull RST_n low after 20 beats.
  - Outputs go to 0 immediately.
  - After release, state is IDLE and any table read returns 0 once the load completes with an all-zero stream.
- Restart mid-load: pulse load_start after 30 beats, then send 64 beats of value 7'h55.
  - In SERVE, every (W, J) returns 0x55.

Source files
------------

// File: rtl/jam_cost_responder.sv
// Responder for the job-assignment solver: serially loaded N x N cost table,
// zero-latency (W, J) lookups, lookup-cycle counting and result capture.
module jam_cost_responder #(
   parameter int unsigned N      = 8,
   parameter int unsigned COST_W = 7,
   parameter int unsigned SUM_W  = 10,
   parameter int unsigned MC_W   = 4,
   parameter int unsigned QCNT_W = 16
) (
   input  logic                    CLK,
   input  logic                    RST_n,
   input  logic                    load_start,
   input  logic                    load_valid,
   input  logic [COST_W-1:0]       load_data,
   output logic                    load_ready,
   input  logic [$clog2(N)-1:0]    W,
   input  logic [$clog2(N)-1:0]    J,
   output logic [COST_W-1:0]       Cost,
   output logic                    serve_ready,
   input  logic                    Valid,
   input  logic [SUM_W-1:0]        MinCost,
   input  logic [MC_W-1:0]         MatchCount,
   output logic                    res_valid,
   output logic [SUM_W-1:0]        res_min_cost,
   output logic [MC_W-1:0]         res_match_count,
   output logic [QCNT_W-1:0]       query_cnt
);

   localparam int unsigned IW    = $clog2(N);
   localparam int unsigned AW    = 2 * IW;
   localparam int unsigned DEPTH = N * N;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SERVE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [QCNT_W-1:0]   qcnt_q, qcnt_d;
   logic                res_valid_q, res_valid_d;
   logic [SUM_W-1:0]    res_min_q, res_min_d;
   logic [MC_W-1:0]     res_mc_q, res_mc_d;
   logic [COST_W-1:0]   table_q [DEPTH];

   logic                wr_en;
   logic [AW-1:0]       wr_addr;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      qcnt_d      = qcnt_q;
      res_valid_d = res_valid_q;
      res_min_d   = res_min_q;
      res_mc_d    = res_mc_q;
      wr_en       = 1'b0;
      wr_addr     = '0;

      // load_start from any non-LOAD state re-enters LOAD and drops stale results
      if (load_start && state_q != LOAD) begin
         state_d     = LOAD;
         addr_d      = '0;
         qcnt_d      = '0;
         res_valid_d = 1'b0;
         res_min_d   = '0;
         res_mc_d    = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (load_start) begin
                  addr_d = '0;
                  if (load_valid) begin
                     wr_en  = 1'b1;
                     wr_addr = '0;
                     addr_d = AW'(1);
                  end
               end else if (load_valid) begin
                  wr_en   = 1'b1;
                  wr_addr = addr_q;
                  if (addr_q == LAST_ADDR) begin
                     state_d = SERVE;
                     addr_d  = '0;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
               end
            end
            SERVE: begin
               if (qcnt_q != '1) qcnt_d = qcnt_q + 1'b1;
               if (Valid) begin
                  res_valid_d = 1'b1;
                  res_min_d   = MinCost;
                  res_mc_d    = MatchCount;
                  state_d     = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         qcnt_q      <= '0;
         res_valid_q <= 1'b0;
         res_min_q   <= '0;
         res_mc_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         qcnt_q      <= qcnt_d;
         res_valid_q <= res_valid_d;
         res_min_q   <= res_min_d;
         res_mc_q    <= res_mc_d;
         if (wr_en) table_q[wr_addr] <= load_data;
      end
   end

   always_comb begin
      Cost = '0;
      if (state_q == SERVE || state_q == DONE) Cost = table_q[{W, J}];
   end

   assign load_ready      = (state_q == LOAD);
   assign serve_ready     = (state_q == SERVE);
   assign res_valid       = res_valid_q;
   assign res_min_cost    = res_min_q;
   assign res_match_count = res_mc_q;
   assign query_cnt       = qcnt_q;

endmodule
